// File: rtl/prng_arbiter.sv
// prng_arbiter: round-robin arbiter that shares one 32-bit PRNG among NUM_REQ
// requesters and owns the generator's advance strobe, so that each delivered
// word is consumed exactly once.
//
// Optional feature: define PRNG_ARB_WARMUP_EN to add a WARMUP state. After
// reset the generator is then advanced WARMUP_CYCLES times before any request
// is served.
//
// Ports:
//   clk            in   1        clock, rising edge
//   rst            in   1        synchronous reset, active high
//   req_i          in   NUM_REQ  request levels, held until granted
//   gnt_o          out  NUM_REQ  one-hot, one-cycle grant; qualifies rnd_o
//   rnd_o          out  32       random word captured at grant
//   ready_o        out  1        arbiter accepting requests (IDLE)
//   prng_next_o    out  1        advance strobe to generator `next`
//   prng_random_i  in   32       current generator output word
module prng_arbiter #(
   parameter int unsigned NUM_REQ       = 4,
   parameter int unsigned WARMUP_CYCLES = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [31:0]        rnd_o,
   output logic               ready_o,
   output logic               prng_next_o,
   input  logic [31:0]        prng_random_i
);

   localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned CNT_W = 8;
   localparam int unsigned RND_W = 32;

   // Elaboration-time parameter range checks.
   if (NUM_REQ < 1 || NUM_REQ > 16) begin : g_bad_num_req
      $error("prng_arbiter: NUM_REQ must be in 1..16");
   end
   if (WARMUP_CYCLES < 1 || WARMUP_CYCLES > 255) begin : g_bad_warmup
      $error("prng_arbiter: WARMUP_CYCLES must be in 1..255");
   end

   typedef enum logic [1:0] {
      ST_WARMUP = 2'd0,
      ST_IDLE   = 2'd1,
      ST_GRANT  = 2'd2
   } state_e;

`ifdef PRNG_ARB_WARMUP_EN
   localparam state_e RESET_STATE = ST_WARMUP;
`else
   localparam state_e RESET_STATE = ST_IDLE;
`endif

   state_e             state_q, state_d;
   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic [RND_W-1:0]   rnd_q, rnd_d;
`ifdef PRNG_ARB_WARMUP_EN
   logic [CNT_W-1:0]   cnt_q, cnt_d;
`endif

   // Round-robin scan results.
   logic               found;
   logic [PTR_W-1:0]   win;
   logic [NUM_REQ-1:0] win_onehot;
   logic [31:0]        scan_sum;
   logic [PTR_W-1:0]   scan_idx;

   // Winner = first requesting index at or above ptr, wrapping around.
   always_comb begin
      found      = 1'b0;
      win        = '0;
      win_onehot = '0;
      scan_sum   = '0;
      scan_idx   = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         scan_sum = 32'(ptr_q) + i;
         if (scan_sum >= NUM_REQ) begin
            scan_sum = scan_sum - NUM_REQ;
         end
         scan_idx = PTR_W'(scan_sum);
         if (!found && req_i[scan_idx]) begin
            found                = 1'b1;
            win                  = scan_idx;
            win_onehot           = '0;
            win_onehot[scan_idx] = 1'b1;
         end
      end
   end

   // Next-state logic; gnt defaults to 0 so it is a single-cycle pulse.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gnt_d   = '0;
      rnd_d   = rnd_q;
`ifdef PRNG_ARB_WARMUP_EN
      cnt_d   = cnt_q;
`endif
      case (state_q)
`ifdef PRNG_ARB_WARMUP_EN
         ST_WARMUP: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q <= CNT_W'(1)) begin
               state_d = ST_IDLE;
            end
         end
`endif
         ST_IDLE: begin
            if (found) begin
               gnt_d   = win_onehot;
               rnd_d   = prng_random_i;
               state_d = ST_GRANT;
               if (32'(win) + 32'd1 >= NUM_REQ) begin
                  ptr_d = '0;
               end else begin
                  ptr_d = win + PTR_W'(1);
               end
            end
         end
         ST_GRANT: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers; synchronous reset wins over everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RESET_STATE;
         ptr_q   <= '0;
         gnt_q   <= '0;
         rnd_q   <= '0;
`ifdef PRNG_ARB_WARMUP_EN
         cnt_q   <= CNT_W'(WARMUP_CYCLES);
`endif
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gnt_q   <= gnt_d;
         rnd_q   <= rnd_d;
`ifdef PRNG_ARB_WARMUP_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   assign gnt_o = gnt_q;
   assign rnd_o = rnd_q;

   // Strobes decode the state register. Masking with rst suppresses the advance
   // pulse of a grant that reset interrupts, and starts warmup pulses in the
   // first cycle after rst falls.
   assign ready_o     = ~rst & (state_q == ST_IDLE);
   assign prng_next_o = ~rst & ((state_q == ST_WARMUP) | (state_q == ST_GRANT));

endmodule

// File: tb/tb_prng_arbiter.sv
// Scoreboard bench for prng_arbiter: the stimulus thread pushes expected
// {grant, word} pairs, and a monitor pops and compares on every grant pulse.
// The generator stub is a counter that advances on each prng_next_o edge.
module tb_prng_arbiter;

`ifdef PRNG_ARB_WARMUP_EN
   localparam int unsigned W = 16;
`else
   localparam int unsigned W = 0;
`endif

   typedef struct packed {
      logic [3:0]  gnt;
      logic [31:0] rnd;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  req = '0;
   logic [3:0]  gnt;
   logic [31:0] rnd;
   logic        ready;
   logic        next;
   logic [31:0] stub;

   int tests = 0;
   int fails = 0;
   int gnt_seen = 0;
   int cyc = 0;
   int last_gnt_cyc = 0;
   exp_t exp_q[$];

   prng_arbiter #(.NUM_REQ(4), .WARMUP_CYCLES(16)) dut (
      .clk           (clk),
      .rst           (rst),
      .req_i         (req),
      .gnt_o         (gnt),
      .rnd_o         (rnd),
      .ready_o       (ready),
      .prng_next_o   (next),
      .prng_random_i (stub)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst) stub <= '0;
      else if (next) stub <= stub + 32'd1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: compare every presented grant with the scoreboard head.
   always @(negedge clk) begin
      if (|gnt) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_grant: got gnt=%b rnd=%h, none expected", gnt, rnd);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("grant_onehot", 32'(gnt), 32'(e.gnt));
            check("grant_word", rnd, e.rnd);
         end
         gnt_seen++;
         last_gnt_cyc = cyc;
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic push(input logic [3:0] g, input int unsigned r);
      exp_t e;
      e.gnt = g;
      e.rnd = 32'(r);
      exp_q.push_back(e);
   endtask

   task automatic wait_grants(input int n, input string name);
      int k = 0;
      while (gnt_seen < n && k < 60) begin
         tick();
         k++;
      end
      check(name, 32'(gnt_seen), 32'(n));
   endtask

   // Release reset and count advance pulses while ready is low.
   task automatic release_and_warmup(input string name);
      int pulses = 0;
      int low = 0;
      int k = 0;
      rst = 1'b0;
      #1;
      while (!ready && k < 300) begin
         if (next) pulses++;
         low++;
         tick();
         k++;
      end
      check({name, "_pulses"}, 32'(pulses), 32'(W));
      check({name, "_ready_low"}, 32'(low), 32'(W));
      check({name, "_ready"}, 32'(ready), 32'd1);
   endtask

   initial begin
      int r_cyc;
      rst = 1'b1;
      req = '0;
      repeat (3) tick();
      check("rst_gnt", 32'(gnt), 32'd0);
      check("rst_rnd", rnd, 32'd0);
      check("rst_ready", 32'(ready), 32'd0);
      check("rst_next", 32'(next), 32'd0);

      // Rotation with all requesting, then wrap/skip with a sparse mask.
      req = 4'b1111;
      push(4'b0001, W + 0);
      push(4'b0010, W + 1);
      push(4'b0100, W + 2);
      push(4'b1000, W + 3);
      push(4'b0001, W + 4);
      release_and_warmup("warmup");
      r_cyc = cyc;
      wait_grants(5, "rotation_count");
      check("rotation_spacing", 32'(last_gnt_cyc - r_cyc), 32'd9);
      push(4'b1000, W + 5);
      req = 4'b1000;
      wait_grants(6, "grant_to_3");
      push(4'b0010, W + 6);
      push(4'b1000, W + 7);
      push(4'b0010, W + 8);
      req = 4'b1010;
      wait_grants(9, "wrap_skip");
      req = 4'b0000;

      // Idle: ready high, no advance.
      tick();
      tick();
      check("idle_ready", 32'(ready), 32'd1);
      check("idle_next", 32'(next), 32'd0);

      // Single-cycle handshake.
      push(4'b0100, W + 9);
      req = 4'b0100;
      tick();
      check("hs_gnt_n1", 32'(gnt), 32'b0100);
      check("hs_next_n1", 32'(next), 32'd1);
      check("hs_ready_n1", 32'(ready), 32'd0);
      req = 4'b0000;
      tick();
      check("hs_gnt_n2", 32'(gnt), 32'd0);
      check("hs_next_n2", 32'(next), 32'd0);
      check("hs_rnd_hold", rnd, 32'(W + 9));

      // Reset during GRANT.
      push(4'b1000, W + 10);
      req = 4'b1100;
      tick();
      check("pre_rst_gnt", 32'(gnt), 32'b1000);
      rst = 1'b1;
      req = 4'b0110;
      #1;
      check("rst_grant_no_next", 32'(next), 32'd0);
      tick();
      check("rst2_gnt", 32'(gnt), 32'd0);
      check("rst2_rnd", rnd, 32'd0);
      check("rst2_ready", 32'(ready), 32'd0);
      check("rst2_next", 32'(next), 32'd0);
      push(4'b0010, W + 0);
      release_and_warmup("rewarm");
      wait_grants(12, "post_reset_grant");
      req = 4'b0000;
      repeat (4) tick();
      check("no_extra_grants", 32'(gnt_seen), 32'd12);
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
      $fatal(1, "watchdog");
   end

endmodule
